wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline-register interface: the writeback stage plus the architectural register file of the 5-stage MIPS pipeline.
- Takes the registered MEM/WB control, ALU result, load data and destination register.
- Selects the writeback value and commits it to a 32x32 register file on the clock edge.
- Serves the two decode-stage read ports with same-cycle write bypass; also keeps a retired-write counter for debug.

Parameters:
- DATA_W, 32, datapath and register width
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)
- CNT_W, 32, retired-write counter width

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_ctrl  input  2  MEM/WB control: bit1 RegWrite, bit0 MemtoReg
- wb_alu  input  DATA_W  ALU result from MEM/WB
- wb_read_data  input  DATA_W  data-memory load value from MEM/WB
- wb_dest  input  ADDR_W  destination register index from MEM/WB
- rs_addr  input  ADDR_W  decode read port A index
- rt_addr  input  ADDR_W  decode read port B index
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- wb_data  output  DATA_W  selected writeback value, combinational; fed to the forwarding unit
- wb_we  output  1  effective write enable, combinational
- retire_count  output  CNT_W  number of committed register writes

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0:
  - all NUM_REGS entries clear to 0;
  - retire_count = 0;
  - no write commits, even on a clock edge.
- Reset is released synchronously to the design through the normal edge; the first write may commit on the first rising edge with rst_n=1.
- Writeback select: wb_data = wb_ctrl[0] ? wb_read_data : wb_alu. Purely combinational, no latency.
- Write enable: wb_we = wb_ctrl[1] and (wb_dest != 0).
- Register 0 is hardwired zero: never written, always reads 0.
- Commit: on rising clk with rst_n=1 and wb_we=1, reg[wb_dest] <= wb_data. One write per cycle; latency one edge.
- Read ports are combinational with write-first bypass. rs_data is:
  - 0 if rs_addr == 0;
  - else wb_data if wb_we and rs_addr == wb_dest;
  - else reg[rs_addr].
- rt_data follows the same rule with rt_addr.
- Both ports may read the same register. Both may hit the bypass simultaneously and both return wb_data.
- A write with wb_ctrl[1]=1 and wb_dest=0 is discarded: no state change and no counter increment.
- Counter: retire_count increments by 1 on each committed write (wb_we=1 at the edge). It wraps modulo 2**CNT_W with no saturation or flag.
- Reset asserted mid-operation: state clears immediately, regardless of clk. A write presented in the same cycle is lost. Read outputs reflect the cleared file, plus the bypass if wb_we is still asserted.
- Unknown or X on wb_ctrl is not masked. Upstream guarantees wb_ctrl = 2'b00 out of reset.

Decomposition:
- Shared package pipeline_pkg holds:
  - DATA_W and ADDR_W;
  - WB control bit positions (WB_REGWRITE=1, WB_MEMTOREG=0);
  - REG_ZERO = 0.
- One sub-module: regfile_2r1w. It is the storage array with async active-low clear, one synchronous write port, two combinational read ports and the zero-register rule.
- wb_regfile adds around it: writeback mux, write-enable qualification, bypass muxes and retire counter.

Test Plan:
- Reset clear: drive rst_n=0 mid-run after writing reg5=0xDEADBEEF -> rs_addr=5 reads 0 immediately (no clock needed); retire_count=0.
- ALU writeback: wb_ctrl=2'b10, wb_alu=0x00000011, wb_dest=8, one edge; then wb_ctrl=0 -> rs_addr=8 reads 0x00000011; retire_count=1.
- Load writeback and bypass: wb_ctrl=2'b11, wb_read_data=0xCAFEF00D, wb_alu=0x1, wb_dest=9, rs_addr=rt_addr=9 before the edge -> both ports already read 0xCAFEF00D and wb_data=0xCAFEF00D; after the edge, reg9 holds 0xCAFEF00D.
- Register-zero guard: wb_ctrl=2'b10, wb_dest=0, wb_alu=0xFFFFFFFF -> wb_we=0; rs_addr=0 reads 0; retire_count unchanged.
- No-write cycle: wb_ctrl=2'b01, wb_dest=4, after writing reg4=0x7 earlier -> reg4 stays 0x7; no bypass on rt_addr=4; counter unchanged.
- Counter wrap: with CNT_W=4, commit 17 writes to reg1..reg17 -> retire_count=1; each register holds its written value.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths and MEM/WB control bit positions for the pipeline
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // MEM/WB control word bit positions
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Architectural register that is hardwired to zero
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB writeback and decode read-port bundle for wb_regfile
interface wb_regfile_if #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int CNT_W  = 32
);

  logic [1:0]        wb_ctrl;
  logic [DATA_W-1:0] wb_alu;
  logic [DATA_W-1:0] wb_read_data;
  logic [ADDR_W-1:0] wb_dest;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [CNT_W-1:0]  retire_count;

  // Pipeline side: drives MEM/WB register contents and decode read indices
  modport master (
    output wb_ctrl, wb_alu, wb_read_data, wb_dest, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_we, retire_count
  );

  // Writeback stage / register file side
  modport slave (
    input  wb_ctrl, wb_alu, wb_read_data, wb_dest, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_we, retire_count
  );

endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - register array with async clear, one write port, two read ports, r0 hardwired zero
module regfile_2r1w
  import pipeline_pkg::*;
#(
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int ADDR_W   = pipeline_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  // Next array state: at most one entry replaced, r0 never written
  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != ADDR_W'(REG_ZERO))) begin
      mem_d[waddr] = wdata;
    end
  end

  // Array storage, cleared asynchronously so reset wins over any pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read ports; r0 forced to zero regardless of array contents
  always_comb begin
    rdata_a = (raddr_a == ADDR_W'(REG_ZERO)) ? '0 : mem_q[raddr_a];
    rdata_b = (raddr_b == ADDR_W'(REG_ZERO)) ? '0 : mem_q[raddr_b];
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage: result select, write qualification, bypassed reads, retire counter
module wb_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int ADDR_W   = pipeline_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);

  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // Writeback select and effective write enable (writes to r0 are dropped here)
  always_comb begin
    wb_data = bus.wb_ctrl[WB_MEMTOREG] ? bus.wb_read_data : bus.wb_alu;
    wb_we   = bus.wb_ctrl[WB_REGWRITE] && (bus.wb_dest != ADDR_W'(REG_ZERO));
  end

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_we),
    .waddr   (bus.wb_dest),
    .wdata   (wb_data),
    .raddr_a (bus.rs_addr),
    .raddr_b (bus.rt_addr),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b)
  );

  // Write-first bypass so decode sees the value being committed this cycle
  always_comb begin
    if (bus.rs_addr == ADDR_W'(REG_ZERO)) begin
      bus.rs_data = '0;
    end else if (wb_we && (bus.rs_addr == bus.wb_dest)) begin
      bus.rs_data = wb_data;
    end else begin
      bus.rs_data = rf_rdata_a;
    end

    if (bus.rt_addr == ADDR_W'(REG_ZERO)) begin
      bus.rt_data = '0;
    end else if (wb_we && (bus.rt_addr == bus.wb_dest)) begin
      bus.rt_data = wb_data;
    end else begin
      bus.rt_data = rf_rdata_b;
    end
  end

  // Retired-write count, wraps naturally at 2**CNT_W
  always_comb begin
    cnt_d = cnt_q + CNT_W'(wb_we);
  end

  // Counter register, cleared with the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.wb_data      = wb_data;
  assign bus.wb_we        = wb_we;
  assign bus.retire_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  typedef struct {
    logic [1:0]    ctrl;
    logic [DW-1:0] alu;
    logic [DW-1:0] rd;
    logic [AW-1:0] dest;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] e_wb;
    logic          e_we;
    logic [DW-1:0] e_rs;
    logic [DW-1:0] e_rt;
    logic [CW-1:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] e_wb;
    logic          e_we;
    logic [DW-1:0] e_rs;
    logic [DW-1:0] e_rt;
    logic [CW-1:0] e_cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  vec_t vecs[8];
  exp_t sb[$];

  wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus();

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ctrl, input logic [DW-1:0] alu, input logic [DW-1:0] rd,
                       input logic [AW-1:0] dest, input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    bus.wb_ctrl      = ctrl;
    bus.wb_alu       = alu;
    bus.wb_read_data = rd;
    bus.wb_dest      = dest;
    bus.rs_addr      = rs;
    bus.rt_addr      = rt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;

    vecs[0] = '{2'b10, 32'h00000011, 32'h0,        5'd8,  5'd8,  5'd0,  32'h00000011, 1'b1, 32'h00000011, 32'h0,        4'd1};
    vecs[1] = '{2'b00, 32'h00000055, 32'h0,        5'd8,  5'd8,  5'd8,  32'h00000055, 1'b0, 32'h00000011, 32'h00000011, 4'd1};
    vecs[2] = '{2'b11, 32'h00000001, 32'hCAFEF00D, 5'd9,  5'd9,  5'd9,  32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 4'd2};
    vecs[3] = '{2'b00, 32'h0,        32'h0,        5'd0,  5'd9,  5'd8,  32'h0,        1'b0, 32'hCAFEF00D, 32'h00000011, 4'd2};
    vecs[4] = '{2'b10, 32'hFFFFFFFF, 32'h0,        5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        4'd2};
    vecs[5] = '{2'b10, 32'h00000007, 32'h0,        5'd4,  5'd4,  5'd5,  32'h00000007, 1'b1, 32'h00000007, 32'h0,        4'd3};
    vecs[6] = '{2'b01, 32'h00000099, 32'h00000BAD, 5'd4,  5'd4,  5'd4,  32'h00000BAD, 1'b0, 32'h00000007, 32'h00000007, 4'd3};
    vecs[7] = '{2'b10, 32'h00001234, 32'h0,        5'd31, 5'd31, 5'd30, 32'h00001234, 1'b1, 32'h00001234, 32'h0,        4'd4};

    // Reset state
    rst_n = 1'b0;
    drive(2'b00, '0, '0, '0, 5'd5, 5'd31);
    #3;
    check("reset_rs_r5", bus.rs_data, 32'h0);
    check("reset_rt_r31", bus.rt_data, 32'h0);
    check("reset_count", DW'(bus.retire_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors through the scoreboard
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].ctrl, vecs[i].alu, vecs[i].rd, vecs[i].dest, vecs[i].rs, vecs[i].rt);
      sb.push_back('{vecs[i].e_wb, vecs[i].e_we, vecs[i].e_rs, vecs[i].e_rt, vecs[i].e_cnt});
      #2;
      e = sb.pop_front();
      check($sformatf("v%0d_wb_data", i), bus.wb_data, e.e_wb);
      check($sformatf("v%0d_wb_we", i), DW'(bus.wb_we), DW'(e.e_we));
      check($sformatf("v%0d_rs_data", i), bus.rs_data, e.e_rs);
      check($sformatf("v%0d_rt_data", i), bus.rt_data, e.e_rt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", i), DW'(bus.retire_count), DW'(e.e_cnt));
    end

    // Committed values persist after writes stop
    @(negedge clk);
    drive(2'b00, '0, '0, '0, 5'd31, 5'd4);
    #2;
    check("hold_r31", bus.rs_data, 32'h00001234);
    check("hold_r4", bus.rt_data, 32'h00000007);

    // Mid-run asynchronous reset clears the file without a clock edge
    @(negedge clk);
    drive(2'b10, 32'hDEADBEEF, '0, 5'd5, 5'd0, 5'd0);
    @(negedge clk);
    drive(2'b00, '0, '0, '0, 5'd5, 5'd0);
    #1;
    check("pre_reset_r5", bus.rs_data, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("async_clear_r5", bus.rs_data, 32'h0);
    check("async_clear_count", DW'(bus.retire_count), 32'h0);
    drive(2'b10, 32'h00000ABC, '0, 5'd6, 5'd6, 5'd5);
    #1;
    check("reset_bypass_r6", bus.rs_data, 32'h00000ABC);
    check("reset_rt_r5", bus.rt_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(2'b00, '0, '0, '0, 5'd6, 5'd0);
    rst_n = 1'b1;
    #2;
    check("lost_write_r6", bus.rs_data, 32'h0);
    check("lost_write_count", DW'(bus.retire_count), 32'h0);

    // Counter wrap: 17 commits on a 4-bit counter
    for (int r = 1; r <= 17; r++) begin
      drive(2'b10, 32'h01010101 * r + 32'h100, '0, AW'(r), 5'd0, 5'd0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(2'b00, '0, '0, '0, 5'd0, 5'd0);
    #2;
    check("wrap_count", DW'(bus.retire_count), 32'h1);
    for (int r = 1; r <= 17; r++) begin
      bus.rs_addr = AW'(r);
      bus.rt_addr = AW'(18 - r);
      #1;
      check($sformatf("wrap_rs_r%0d", r), bus.rs_data, 32'h01010101 * r + 32'h100);
      check($sformatf("wrap_rt_r%0d", 18 - r), bus.rt_data, 32'h01010101 * (18 - r) + 32'h100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
